processor_mc: RTL and testbench

// - Multi-cycle successor of the single-cycle core. Adds a data-memory port with a req/ready handshake,

---
 rtl/cpu_pkg.sv | 61 ++++++
 rtl/alu.sv | 38 +++
 rtl/isa_decoder.sv | 75 +++++++
 rtl/regfile.sv | 35 +++
 rtl/processor_mc.sv | 153 +++++++++++++++
 tb/tb_processor_mc.sv | 339 +++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, ALU operation codes,
// FSM state type, instruction field positions and the decoded-control struct.
// No ports (package).
package cpu_pkg;

   // Major opcodes, instruction bits [17:14]
   localparam logic [3:0] OP_ADDI  = 4'd0;
   localparam logic [3:0] OP_LDI   = 4'd1;
   localparam logic [3:0] OP_ALU   = 4'd2;
   localparam logic [3:0] OP_LOAD  = 4'd3;
   localparam logic [3:0] OP_STORE = 4'd4;
   localparam logic [3:0] OP_JMP   = 4'd5;
   localparam logic [3:0] OP_BNZ   = 4'd6;
   localparam logic [3:0] OP_HALT  = 4'd7;

   // ALU operation codes, instruction bits [3:0] for OP_ALU
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SHL  = 4'd5;
   localparam logic [3:0] ALU_SHR  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

   // Instruction field positions
   localparam int unsigned OP_MSB    = 17;
   localparam int unsigned OP_LSB    = 14;
   localparam int unsigned RX_MSB    = 13;
   localparam int unsigned RX_LSB    = 11;
   localparam int unsigned RY_MSB    = 10;
   localparam int unsigned RY_LSB    = 8;
   localparam int unsigned RZ_MSB    = 7;
   localparam int unsigned RZ_LSB    = 5;
   localparam int unsigned ALU_MSB   = 3;
   localparam int unsigned ALU_LSB   = 0;
   localparam int unsigned IMM8_MSB  = 7;
   localparam int unsigned IMM11_MSB = 10;
   localparam int unsigned IMM14_MSB = 13;

   typedef struct packed {
      logic [2:0] ra_addr;   // read port A (ry)
      logic [2:0] rb_addr;   // read port B (rz, or rx for store/bnz)
      logic [2:0] wa_addr;   // destination (rx)
      logic [3:0] alu_op;
      logic       b_imm;     // ALU operand B is the immediate
      logic       use_alu;   // write-back from ALU, else from immediate
      logic       wr_en;     // register write in EXEC
      logic       is_mem;
      logic       is_store;
      logic       is_jump;
      logic       is_branch;
      logic       is_halt;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU shared by ADDI, register-register ops and address generation.
// Ports:
//   a, b  in   WIDTH  operands
//   op    in   4      operation code (ALU_* in cpu_pkg); unknown codes pass a
//   y     out  WIDTH  result, modulo 2**WIDTH
module alu
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH = 18
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic [WIDTH-1:0] y
);

   logic [4:0] shamt;

   assign shamt = b[4:0];

   always_comb begin
      y = a;
      case (op)
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_AND:  y = a & b;
         ALU_OR:   y = a | b;
         ALU_XOR:  y = a ^ b;
         ALU_SHL:  y = a << shamt;
         ALU_SHR:  y = a >> shamt;
         ALU_SRA:  y = $signed(a) >>> shamt;
         ALU_SLT:  y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: y = {{(WIDTH-1){1'b0}}, (a < b)};
         default:  y = a;
      endcase
   end

endmodule

// File: rtl/isa_decoder.sv
// Combinational instruction decoder.
// Ports:
//   code_word  in   WORD_SIZE  instruction (bits [17:0] used)
//   dec        out  dec_t      register addresses and control flags
//   imm        out  WORD_SIZE  sign-extended immediate selected by opcode
module isa_decoder
   import cpu_pkg::*;
#(
   parameter int unsigned WORD_SIZE = 18
) (
   input  logic [WORD_SIZE-1:0] code_word,
   output dec_t                 dec,
   output logic [WORD_SIZE-1:0] imm
);

   logic [3:0]           op;
   logic [WORD_SIZE-1:0] imm8;
   logic [WORD_SIZE-1:0] imm11;
   logic [WORD_SIZE-1:0] imm14;
   logic                 unused_word;

   assign op    = code_word[OP_MSB:OP_LSB];
   assign imm8  = {{(WORD_SIZE-8){code_word[IMM8_MSB]}}, code_word[IMM8_MSB:0]};
   assign imm11 = {{(WORD_SIZE-11){code_word[IMM11_MSB]}}, code_word[IMM11_MSB:0]};
   assign imm14 = {{(WORD_SIZE-14){code_word[IMM14_MSB]}}, code_word[IMM14_MSB:0]};
   assign unused_word = ^code_word;

   always_comb begin
      dec         = '0;
      dec.ra_addr = code_word[RY_MSB:RY_LSB];
      dec.rb_addr = code_word[RZ_MSB:RZ_LSB];
      dec.wa_addr = code_word[RX_MSB:RX_LSB];
      dec.alu_op  = ALU_ADD;
      imm         = imm8;
      case (op)
         OP_ADDI: begin
            dec.b_imm   = 1'b1;
            dec.use_alu = 1'b1;
            dec.wr_en   = 1'b1;
         end
         OP_LDI: begin
            imm       = imm11;
            dec.wr_en = 1'b1;
         end
         OP_ALU: begin
            dec.alu_op  = code_word[ALU_MSB:ALU_LSB];
            dec.use_alu = 1'b1;
            dec.wr_en   = 1'b1;
         end
         OP_LOAD: begin
            // register write happens later, in MEM
            dec.b_imm  = 1'b1;
            dec.is_mem = 1'b1;
         end
         OP_STORE: begin
            dec.b_imm    = 1'b1;
            dec.is_mem   = 1'b1;
            dec.is_store = 1'b1;
            dec.rb_addr  = code_word[RX_MSB:RX_LSB];
         end
         OP_JMP: begin
            imm         = imm14;
            dec.is_jump = 1'b1;
         end
         OP_BNZ: begin
            imm           = imm11;
            dec.is_branch = 1'b1;
            dec.rb_addr   = code_word[RX_MSB:RX_LSB];
         end
         OP_HALT: dec.is_halt = 1'b1;
         default: dec.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/regfile.sv
// Architectural register file: two combinational read ports, one write port.
// Ports:
//   clock, reset        clock and async active-high reset (clears all registers)
//   ra_addr/ra_data     read port A
//   rb_addr/rb_data     read port B
//   we/wa_addr/wa_data  write port, written on the rising edge when we=1
module regfile #(
   parameter int unsigned WIDTH = 18,
   parameter int unsigned COUNT = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [2:0]       ra_addr,
   output logic [WIDTH-1:0] ra_data,
   input  logic [2:0]       rb_addr,
   output logic [WIDTH-1:0] rb_data,
   input  logic             we,
   input  logic [2:0]       wa_addr,
   input  logic [WIDTH-1:0] wa_data
);

   logic [WIDTH-1:0] regs [COUNT];

   assign ra_data = regs[ra_addr];
   assign rb_data = regs[rb_addr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < COUNT; i++) regs[i] <= '0;
      end else if (we) begin
         regs[wa_addr] <= wa_data;
      end
   end

endmodule

// File: rtl/processor_mc.sv
// Multi-cycle processor core: FETCH -> EXEC -> {FETCH | MEM | HALT}.
// Ports:
//   clock, reset     rising-edge clock, async active-high reset
//   code_addr        fetch address (= ip); code_word is valid one cycle later
//   code_word        instruction from the synchronous code ROM
//   data_req/we      data access request (held until data_ready) and direction
//   data_addr/wdata  effective address (ry + sext(imm8)) and store data (rx)
//   data_rdata       load data, sampled in the data_ready cycle
//   data_ready       completes the current access
//   halted           high while in HALT
//   illegal_op       one-cycle pulse after executing an undefined opcode
// ADDR_SIZE must not exceed WORD_SIZE: addresses come from the low ALU bits.
module processor_mc
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_SIZE = 18,
   parameter int unsigned WORD_SIZE = 18,
   parameter int unsigned REG_COUNT = 8,
   parameter int unsigned RESET_IP  = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   output logic [ADDR_SIZE-1:0] code_addr,
   input  logic [WORD_SIZE-1:0] code_word,
   output logic                 data_req,
   output logic                 data_we,
   output logic [ADDR_SIZE-1:0] data_addr,
   output logic [WORD_SIZE-1:0] data_wdata,
   input  logic [WORD_SIZE-1:0] data_rdata,
   input  logic                 data_ready,
   output logic                 halted,
   output logic                 illegal_op
);

   localparam logic [ADDR_SIZE-1:0] RESET_IP_V = ADDR_SIZE'(RESET_IP);
   localparam logic [ADDR_SIZE-1:0] IP_ONE     = ADDR_SIZE'(1);

   state_t               state;
   logic [ADDR_SIZE-1:0] ip;
   logic [2:0]           load_rd;

   dec_t                 dec;
   logic [WORD_SIZE-1:0] imm;
   logic [WORD_SIZE-1:0] ra_data;
   logic [WORD_SIZE-1:0] rb_data;
   logic [WORD_SIZE-1:0] alu_b;
   logic [WORD_SIZE-1:0] alu_y;
   logic [ADDR_SIZE-1:0] ip_inc;
   logic [ADDR_SIZE-1:0] ip_rel;
   logic [ADDR_SIZE-1:0] ip_exec;
   logic                 load_done;
   logic                 rf_we;
   logic [2:0]           rf_wa;
   logic [WORD_SIZE-1:0] rf_wd;

   isa_decoder #(
      .WORD_SIZE (WORD_SIZE)
   ) u_decoder (
      .code_word (code_word),
      .dec       (dec),
      .imm       (imm)
   );

   regfile #(
      .WIDTH (WORD_SIZE),
      .COUNT (REG_COUNT)
   ) u_regfile (
      .clock   (clock),
      .reset   (reset),
      .ra_addr (dec.ra_addr),
      .ra_data (ra_data),
      .rb_addr (dec.rb_addr),
      .rb_data (rb_data),
      .we      (rf_we),
      .wa_addr (rf_wa),
      .wa_data (rf_wd)
   );

   alu #(
      .WIDTH (WORD_SIZE)
   ) u_alu (
      .a  (ra_data),
      .b  (alu_b),
      .op (dec.alu_op),
      .y  (alu_y)
   );

   assign code_addr = ip;
   assign alu_b     = dec.b_imm ? imm : rb_data;

   // Relative targets use the truncated sign-extended immediate: modulo 2**ADDR_SIZE.
   assign ip_inc = ip + IP_ONE;
   assign ip_rel = ip + imm[ADDR_SIZE-1:0];

   always_comb begin
      ip_exec = ip_inc;
      if (dec.is_jump || (dec.is_branch && (rb_data != '0))) ip_exec = ip_rel;
   end

   // data_req is only ever high in MEM, so a stray data_ready elsewhere is ignored.
   assign load_done = (state == MEM) && data_req && data_ready && !data_we;
   assign rf_we     = ((state == EXEC) && dec.wr_en) || load_done;
   assign rf_wa     = (state == MEM) ? load_rd : dec.wa_addr;
   assign rf_wd     = (state == MEM) ? data_rdata : (dec.use_alu ? alu_y : imm);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= FETCH;
         ip         <= RESET_IP_V;
         load_rd    <= '0;
         data_req   <= 1'b0;
         data_we    <= 1'b0;
         data_addr  <= '0;
         data_wdata <= '0;
         halted     <= 1'b0;
         illegal_op <= 1'b0;
      end else begin
         illegal_op <= 1'b0;
         case (state)
            FETCH: state <= EXEC;
            EXEC: begin
               if (dec.is_halt) begin
                  state  <= HALT;
                  halted <= 1'b1;
               end else if (dec.is_mem) begin
                  // ip stays put until the access completes
                  state      <= MEM;
                  data_req   <= 1'b1;
                  data_we    <= dec.is_store;
                  data_addr  <= alu_y[ADDR_SIZE-1:0];
                  data_wdata <= rb_data;
                  load_rd    <= dec.wa_addr;
               end else begin
                  state      <= FETCH;
                  ip         <= ip_exec;
                  illegal_op <= dec.illegal;
               end
            end
            MEM: begin
               if (data_ready) begin
                  state    <= FETCH;
                  data_req <= 1'b0;
                  data_we  <= 1'b0;
                  ip       <= ip_inc;
               end
            end
            HALT:    state <= HALT;
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_processor_mc.sv
// Scoreboard bench for processor_mc: directed programs push expected data-port,
// halt and illegal-op events; a negedge monitor pops and compares them.
module tb_processor_mc;
   import cpu_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [17:0] code_addr;
   logic [17:0] code_word = '0;
   logic        data_req;
   logic        data_we;
   logic [17:0] data_addr;
   logic [17:0] data_wdata;
   logic [17:0] data_rdata = '0;
   logic        data_ready = 1'b0;
   logic        halted;
   logic        illegal_op;

   processor_mc dut (
      .clock      (clock),
      .reset      (reset),
      .code_addr  (code_addr),
      .code_word  (code_word),
      .data_req   (data_req),
      .data_we    (data_we),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .data_rdata (data_rdata),
      .data_ready (data_ready),
      .halted     (halted),
      .illegal_op (illegal_op)
   );

   always #5 clock = ~clock;

   typedef struct {
      int kind;   // 0 mem access, 1 halt, 2 illegal
      bit we;
      int addr;   // data_addr for mem, code_addr otherwise
      int data;
      int num;    // request length for mem, cycle number otherwise
   } ev_t;

   ev_t         sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [17:0] rom [64];
   logic [17:0] ram [64];
   int          ready_delay = 0;
   bit          spurious = 0;
   int          wait_cnt = 0;
   int          cyc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [17:0] enc_i8(logic [3:0] op, int rx, int ry, int imm);
      return {op, 3'(rx), 3'(ry), 8'(imm)};
   endfunction
   function automatic logic [17:0] enc_i11(logic [3:0] op, int rx, int imm);
      return {op, 3'(rx), 11'(imm)};
   endfunction
   function automatic logic [17:0] enc_alu(int rx, int ry, int rz, logic [3:0] aop);
      return {OP_ALU, 3'(rx), 3'(ry), 3'(rz), 1'b0, aop};
   endfunction
   function automatic logic [17:0] enc_jmp(int imm);
      return {OP_JMP, 14'(imm)};
   endfunction
   function automatic logic [17:0] enc_halt();
      return {OP_HALT, 14'd0};
   endfunction

   task automatic push(input int kind, input bit we, input int addr, input int data,
                       input int num);
      ev_t e;
      e.kind = kind; e.we = we; e.addr = addr; e.data = data; e.num = num;
      sb.push_back(e);
   endtask

   // Code ROM: synchronous one-cycle read
   always @(posedge clock) code_word <= rom[code_addr[5:0]];

   // Data responder: ready after ready_delay wait cycles of a request
   always @(posedge clock) begin
      #1;
      if (data_req && !reset) begin
         data_ready = (wait_cnt == ready_delay);
         wait_cnt++;
         data_rdata = ram[data_addr[5:0]];
      end else begin
         wait_cnt   = 0;
         data_ready = spurious;
         data_rdata = 18'h31111;
      end
   end

   always @(posedge clock or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   // Monitor
   int          req_len = 0;
   bit          stable = 1;
   bit          chk_drop = 0;
   bit          prev_halted = 0;
   logic        l_we;
   logic [17:0] l_addr;
   logic [17:0] l_wdata;

   task automatic pop_ev(input int kind, input string name, output ev_t e, output bit ok);
      ok = 0;
      if (sb.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: got unexpected event kind %0d, expected none", name, kind);
      end else begin
         e = sb.pop_front();
         chk({name, "_kind"}, kind, e.kind);
         ok = (kind == e.kind);
      end
   endtask

   always @(negedge clock) begin
      ev_t e;
      bit  ok;
      if (reset) begin
         req_len     = 0;
         chk_drop    = 0;
         prev_halted = 0;
      end else begin
         if (chk_drop) begin
            chk("req_drop", data_req, 0);
            chk_drop = 0;
         end
         if (data_req) begin
            if (req_len == 0) begin
               l_we = data_we; l_addr = data_addr; l_wdata = data_wdata; stable = 1;
            end else if (data_we !== l_we || data_addr !== l_addr || data_wdata !== l_wdata) begin
               stable = 0;
            end
            req_len++;
            if (data_ready) begin
               pop_ev(0, "mem", e, ok);
               if (ok) begin
                  chk("mem_we", data_we, e.we);
                  chk("mem_addr", data_addr, e.addr);
                  if (e.we) chk("mem_wdata", data_wdata, e.data);
                  chk("req_cycles", req_len, e.num);
                  chk("req_stable", stable, 1);
               end
               req_len  = 0;
               chk_drop = 1;
            end
         end
         if (halted && !prev_halted) begin
            pop_ev(1, "halt", e, ok);
            if (ok) begin
               chk("halt_addr", code_addr, e.addr);
               chk("halt_cycle", cyc, e.num);
            end
         end
         if (illegal_op) begin
            pop_ev(2, "illegal", e, ok);
            if (ok) begin
               chk("illegal_next_addr", code_addr, e.addr);
               chk("illegal_cycle", cyc, e.num);
            end
         end
         prev_halted = halted;
      end
   end

   task automatic begin_test(input int delay, input bit spur);
      @(negedge clock);
      reset = 1'b1;
      sb.delete();
      ready_delay = delay;
      spurious    = spur;
      for (int i = 0; i < 64; i++) begin
         rom[i] = enc_halt();
         ram[i] = 18'(i * 3 + 1);
      end
   endtask

   task automatic release_reset();
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic finish_test(input string name, input int budget);
      int n = 0;
      while (!halted && n < budget) begin
         @(negedge clock);
         n++;
      end
      if (!halted) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_timeout: got halted=0 after %0d cycles, expected halted=1", name, n);
      end
      repeat (2) @(negedge clock);
      chk({name, "_sb_empty"}, sb.size(), 0);
   endtask

   initial begin
      // 1: ldi, addi with negative immediate, halt
      begin_test(0, 0);
      #1;
      chk("rst_code_addr", code_addr, 0);
      chk("rst_data_req", data_req, 0);
      chk("rst_data_we", data_we, 0);
      chk("rst_halted", halted, 0);
      chk("rst_illegal", illegal_op, 0);
      rom[0] = enc_i11(OP_LDI, 1, 5);
      rom[1] = enc_i8(OP_ADDI, 2, 1, -3);
      rom[2] = enc_halt();
      push(1, 0, 2, 0, 6);
      release_reset();
      finish_test("t1", 100);
      chk("t1_r2", dut.u_regfile.regs[2], 2);
      repeat (3) @(negedge clock);
      chk("t1_halt_addr_hold", code_addr, 2);
      chk("t1_halted_hold", halted, 1);

      // 2: store with three wait cycles
      begin_test(3, 0);
      rom[0] = enc_i11(OP_LDI, 1, 5);
      rom[1] = enc_i8(OP_ADDI, 2, 1, -3);
      rom[2] = enc_i8(OP_STORE, 2, 0, 4);
      rom[3] = enc_halt();
      push(0, 1, 4, 2, 4);
      push(1, 0, 3, 0, 12);
      release_reset();
      finish_test("t2", 100);

      // 3: load with same-cycle ready, stray ready while idle
      begin_test(0, 1);
      ram[4] = 18'h21234;
      rom[0] = enc_i8(OP_LOAD, 3, 0, 4);
      rom[1] = enc_i8(OP_STORE, 3, 0, 5);
      rom[2] = enc_halt();
      push(0, 0, 4, 0, 1);
      push(0, 1, 5, 'h21234, 1);
      push(1, 0, 2, 0, 8);
      release_reset();
      finish_test("t3", 100);
      chk("t3_r3", dut.u_regfile.regs[3], 'h21234);

      // 4: countdown loop with bnz
      begin_test(0, 0);
      rom[0] = enc_i11(OP_LDI, 1, 3);
      rom[1] = enc_i8(OP_ADDI, 1, 1, -1);
      rom[2] = enc_i11(OP_BNZ, 1, -1);
      rom[3] = enc_halt();
      push(1, 0, 3, 0, 16);
      release_reset();
      finish_test("t4", 100);
      chk("t4_r1", dut.u_regfile.regs[1], 0);

      // 5: jump to 7, undefined opcode 0xC there
      begin_test(0, 0);
      rom[0] = enc_jmp(7);
      rom[7] = {4'hC, 3'd1, 3'd0, 8'h05};
      rom[8] = enc_halt();
      push(2, 0, 8, 0, 4);
      push(1, 0, 8, 0, 6);
      release_reset();
      finish_test("t5", 100);
      chk("t5_r1", dut.u_regfile.regs[1], 0);

      // 7: ip wrap, ALU ops, read-after-write chain, negative address offsets
      begin_test(1, 1);
      ram[11] = 18'h155AA;
      rom[0]  = enc_i11(OP_BNZ, 6, 2);
      rom[1]  = enc_jmp(-2);
      rom[63] = enc_i11(OP_LDI, 6, 1);
      rom[2]  = enc_i11(OP_LDI, 1, 12);
      rom[3]  = enc_i11(OP_LDI, 2, -3);
      rom[4]  = enc_alu(3, 1, 2, ALU_ADD);
      rom[5]  = enc_alu(4, 1, 2, ALU_SUB);
      rom[6]  = enc_alu(5, 2, 1, ALU_AND);
      rom[7]  = enc_alu(7, 2, 1, ALU_SLT);
      rom[8]  = enc_i8(OP_STORE, 3, 0, 16);
      rom[9]  = enc_i8(OP_STORE, 4, 0, 17);
      rom[10] = enc_i8(OP_STORE, 5, 0, 18);
      rom[11] = enc_i8(OP_STORE, 7, 0, 19);
      rom[12] = enc_alu(3, 1, 2, ALU_XOR);
      rom[13] = enc_alu(4, 1, 6, ALU_SHL);
      rom[14] = enc_i8(OP_STORE, 3, 0, 20);
      rom[15] = enc_i8(OP_STORE, 4, 0, 21);
      rom[16] = enc_i8(OP_LOAD, 5, 1, -1);
      rom[17] = enc_i8(OP_STORE, 5, 2, 30);
      rom[18] = enc_halt();
      push(0, 1, 16, 9, 2);
      push(0, 1, 17, 15, 2);
      push(0, 1, 18, 12, 2);
      push(0, 1, 19, 1, 2);
      push(0, 1, 20, 'h3FFF1, 2);
      push(0, 1, 21, 24, 2);
      push(0, 0, 11, 0, 2);
      push(0, 1, 27, 'h155AA, 2);
      push(1, 0, 18, 0, 58);
      release_reset();
      finish_test("t7", 200);

      // 6: reset asserted while a load waits for data_ready
      begin_test(20, 0);
      ram[4] = 18'h12345;
      rom[0] = enc_i8(OP_LOAD, 3, 0, 4);
      release_reset();
      begin
         int n = 0;
         while (!data_req && n < 20) begin
            @(negedge clock);
            n++;
         end
      end
      chk("t6_req_seen", data_req, 1);
      repeat (2) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      chk("t6_req_async_drop", data_req, 0);
      release_reset();
      #1;
      chk("t6_ip_reset", code_addr, 0);
      chk("t6_r3_unchanged", dut.u_regfile.regs[3], 0);
      chk("t6_halted", halted, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
